// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
//
// Purpose:
//   Downstream stage of the 6x2 combinational multiplier. Sums batches of COUNT
//   unsigned products taken over a valid/ready input handshake. Each finished
//   batch sum is presented over a valid/ready output handshake, together with a
//   per-batch sticky overflow flag.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   The sender holds valid/data until that edge. valid without ready is ignored
//   and is not queued. On the input side, clear=1 drops any product offered in
//   the same cycle.
//
// Configuration macro:
//   SATURATE_EN - when defined, an add that carries out clamps the accumulator
//                 to 2^ACC_W-1. When undefined, the add wraps modulo 2^ACC_W.
//                 overflow is reported in both builds.
//
// Parameters:
//   PROD_W  product width (ACC_W >= PROD_W)
//   ACC_W   accumulator / sum width
//   COUNT   products per batch (COUNT >= 1)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   product is valid
//   in_ready   out  block can accept a product (0 while in reset and in HOLD)
//   product    in   [PROD_W-1:0] unsigned multiplier output
//   clear      in   synchronous batch abort, highest priority below reset
//   out_valid  out  sum is valid (batch complete, waiting for consumer)
//   out_ready  in   consumer takes sum
//   sum        out  [ACC_W-1:0] batch sum, meaningful only while out_valid=1
//   overflow   out  sticky per batch: some add in this batch carried out
// -----------------------------------------------------------------------------
module product_accumulator #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 12,
    parameter int COUNT  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] product,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  sum,
    output logic              overflow
);

    localparam int CNT_W = $clog2(COUNT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_next;
    logic [ACC_W-1:0]  sum_r;
    logic [ACC_W-1:0]  sum_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              ovf;
    logic              ovf_next;
    logic              ready_en;
    logic              accept;
    logic              last;
    logic [ACC_W:0]    add_full;
    logic [ACC_W-1:0]  add_val;

    // ready_en keeps in_ready low during reset and raises it on the first
    // edge after release, independent of the FSM state.
    assign in_ready  = ready_en & (state != HOLD);
    assign out_valid = (state == HOLD);
    assign sum       = sum_r;
    assign overflow  = ovf;

    assign accept = in_valid & in_ready & ~clear;
    assign last   = (cnt == CNT_W'(COUNT - 1));

    // One extra bit on the add captures the carry-out used for overflow.
    assign add_full = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, product};

`ifdef SATURATE_EN
    assign add_val = add_full[ACC_W] ? {ACC_W{1'b1}} : add_full[ACC_W-1:0];
`else
    assign add_val = add_full[ACC_W-1:0];
`endif

    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        ovf_next   = ovf;
        sum_next   = sum_r;

        if (clear) begin
            state_next = IDLE;
            acc_next   = '0;
            cnt_next   = '0;
            ovf_next   = 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc_next = add_val;
                        cnt_next = cnt + CNT_W'(1);
                        ovf_next = ovf | add_full[ACC_W];
                        if (last) begin
                            // Batch complete: capture the final sum directly
                            // from the adder so it is valid in HOLD.
                            state_next = HOLD;
                            sum_next   = add_val;
                        end else begin
                            state_next = ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_next = IDLE;
                        acc_next   = '0;
                        cnt_next   = '0;
                        ovf_next   = 1'b0;
                    end
                end
                default: begin
                    state_next = IDLE;
                    acc_next   = '0;
                    cnt_next   = '0;
                    ovf_next   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            sum_r    <= '0;
            ready_en <= 1'b0;
        end else begin
            state    <= state_next;
            acc      <= acc_next;
            cnt      <= cnt_next;
            ovf      <= ovf_next;
            sum_r    <= sum_next;
            ready_en <= 1'b1;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// -----------------------------------------------------------------------------
// tb_product_accumulator
//
// Purpose:
//   Self-checking bench for product_accumulator. Two instances are used: the
//   default configuration (ACC_W=12, COUNT=4) and a narrow one (ACC_W=8,
//   COUNT=2) that reaches overflow easily. A batch-level model (list of
//   accepted products, running arithmetic sum) predicts in_ready, out_valid,
//   sum and overflow; a compare process checks them every cycle. Directed
//   scenarios add literal expectations, then random traffic follows.
// -----------------------------------------------------------------------------
module tb_product_accumulator;

    localparam int PROD_W = 8;
    localparam int ACC_W  = 12;
    localparam int COUNT  = 4;
    localparam int ACC_WB = 8;
    localparam int COUNTB = 2;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT A (12-bit, batch of 4) ----------------
    logic              in_valid  = 1'b0;
    logic              in_ready;
    logic [PROD_W-1:0] product   = '0;
    logic              clear     = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ACC_W-1:0]  sum;
    logic              overflow;

    product_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .COUNT(COUNT)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .product   (product),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .overflow  (overflow)
    );

    // ---------------- DUT B (8-bit, batch of 2) ----------------
    logic              in_valid_b  = 1'b0;
    logic              in_ready_b;
    logic [PROD_W-1:0] product_b   = '0;
    logic              clear_b     = 1'b0;
    logic              out_valid_b;
    logic              out_ready_b = 1'b0;
    logic [ACC_WB-1:0] sum_b;
    logic              overflow_b;

    product_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_WB), .COUNT(COUNTB)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .product   (product_b),
        .clear     (clear_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready_b),
        .sum       (sum_b),
        .overflow  (overflow_b)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Adds one product to a running batch sum using plain integer arithmetic.
    task automatic model_add(input int acc_w, input int p, inout int s, inout bit o);
        int mx;
        int t;
        mx = (1 << acc_w) - 1;
        t  = s + p;
        if (t > mx) begin
            o = 1'b1;
`ifdef SATURATE_EN
            s = mx;
`else
            s = t - (mx + 1);
`endif
        end else begin
            s = t;
        end
    endtask

    // ---------------- behavioural models ----------------
    // A batch is the list of accepted products; the batch is complete when the
    // list holds COUNT entries, and then it waits for out_ready.
    logic [PROD_W-1:0] exp_q[$];
    int                m_sum = 0;
    bit                m_ovf = 1'b0;
    bit                m_rdy = 1'b0;

    logic [PROD_W-1:0] exp_q_b[$];
    int                m_sum_b = 0;
    bit                m_ovf_b = 1'b0;
    bit                m_rdy_b = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_sum = 0;
            m_ovf = 1'b0;
            m_rdy = 1'b0;
            exp_q_b.delete();
            m_sum_b = 0;
            m_ovf_b = 1'b0;
            m_rdy_b = 1'b0;
        end else begin
            if (clear) begin
                exp_q.delete();
                m_sum = 0;
                m_ovf = 1'b0;
            end else if (exp_q.size() == COUNT) begin
                if (out_ready) begin
                    exp_q.delete();
                    m_sum = 0;
                    m_ovf = 1'b0;
                end
            end else if (in_valid && m_rdy) begin
                exp_q.push_back(product);
                model_add(ACC_W, int'(product), m_sum, m_ovf);
            end
            m_rdy = 1'b1;

            if (clear_b) begin
                exp_q_b.delete();
                m_sum_b = 0;
                m_ovf_b = 1'b0;
            end else if (exp_q_b.size() == COUNTB) begin
                if (out_ready_b) begin
                    exp_q_b.delete();
                    m_sum_b = 0;
                    m_ovf_b = 1'b0;
                end
            end else if (in_valid_b && m_rdy_b) begin
                exp_q_b.push_back(product_b);
                model_add(ACC_WB, int'(product_b), m_sum_b, m_ovf_b);
            end
            m_rdy_b = 1'b1;
        end
    end

    // ---------------- compare process (opposite edge) ----------------
    always @(negedge clk) begin
        check("a_in_ready",  32'(in_ready),  32'(m_rdy && exp_q.size() != COUNT));
        check("a_out_valid", 32'(out_valid), 32'(exp_q.size() == COUNT));
        if (exp_q.size() == COUNT) begin
            check("a_sum",      32'(sum),      32'(m_sum));
            check("a_overflow", 32'(overflow), 32'(m_ovf));
        end
        check("b_in_ready",  32'(in_ready_b),  32'(m_rdy_b && exp_q_b.size() != COUNTB));
        check("b_out_valid", 32'(out_valid_b), 32'(exp_q_b.size() == COUNTB));
        if (exp_q_b.size() == COUNTB) begin
            check("b_sum",      32'(sum_b),      32'(m_sum_b));
            check("b_overflow", 32'(overflow_b), 32'(m_ovf_b));
        end
    end

    // ---------------- driver tasks ----------------
    // Inputs change 2 time units after a rising edge, then wait for the next.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_a(input bit v, input int p, input bit c, input bit r);
        in_valid  = v;
        product   = PROD_W'(p);
        clear     = c;
        out_ready = r;
        cyc();
    endtask

    task automatic drive_b(input bit v, input int p, input bit c, input bit r);
        in_valid_b  = v;
        product_b   = PROD_W'(p);
        clear_b     = c;
        out_ready_b = r;
        cyc();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        cyc();

        // Reset in the middle of a batch.
        drive_a(1, 5, 0, 0);
        drive_a(1, 7, 0, 0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum",       32'(sum),       32'd0);
        check("rst_overflow",  32'(overflow),  32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        rst_n = 1'b1;
        cyc();
        check("rst_release_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) drive_a(1, 2, 0, 0);
        check("rst_next_batch_valid", 32'(out_valid), 32'd1);
        check("rst_next_batch_sum",   32'(sum),       32'd8);
        drive_a(0, 0, 0, 1);

        // Full batch of maximum products.
        for (int i = 0; i < 4; i++) drive_a(1, 189, 0, 0);
        check("full_valid",    32'(out_valid), 32'd1);
        check("full_sum",      32'(sum),       32'd756);
        check("full_overflow", 32'(overflow),  32'd0);

        // Backpressure in HOLD with a product offered.
        for (int i = 0; i < 5; i++) begin
            drive_a(1, 50, 0, 0);
            check("bp_sum_stable", 32'(sum),      32'd756);
            check("bp_in_ready",   32'(in_ready), 32'd0);
        end
        drive_a(1, 50, 0, 1);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 4; i++) drive_a(1, 25, 0, 0);
        check("bp_next_sum", 32'(sum), 32'd100);
        drive_a(0, 0, 0, 1);

        // clear after two accepts, with a product offered alongside clear.
        drive_a(1, 10, 0, 0);
        drive_a(1, 20, 0, 0);
        drive_a(1, 99, 1, 0);
        drive_a(1, 1, 0, 0);
        drive_a(1, 2, 0, 0);
        drive_a(1, 3, 0, 0);
        drive_a(1, 4, 0, 0);
        check("clear_valid",    32'(out_valid), 32'd1);
        check("clear_sum",      32'(sum),       32'd10);
        check("clear_overflow", 32'(overflow),  32'd0);
        drive_a(0, 0, 0, 1);

        // Gapped input.
        drive_a(1, 3, 0, 0);
        drive_a(0, 77, 0, 0);
        drive_a(1, 6, 0, 0);
        drive_a(1, 9, 0, 0);
        drive_a(0, 88, 0, 0);
        check("gap_not_done", 32'(out_valid), 32'd0);
        drive_a(1, 12, 0, 0);
        check("gap_valid", 32'(out_valid), 32'd1);
        check("gap_sum",   32'(sum),       32'd30);
        drive_a(0, 0, 0, 1);
        drive_a(0, 0, 0, 0);

        // Overflow on the narrow instance.
        drive_b(1, 189, 0, 0);
        drive_b(1, 189, 0, 0);
        check("ovf_valid",    32'(out_valid_b), 32'd1);
`ifdef SATURATE_EN
        check("ovf_sum",      32'(sum_b),       32'd255);
`else
        check("ovf_sum",      32'(sum_b),       32'd122);
`endif
        check("ovf_overflow", 32'(overflow_b),  32'd1);
        drive_b(0, 0, 0, 1);
        drive_b(1, 7, 0, 0);
        drive_b(1, 8, 0, 0);
        check("ovf_next_sum",      32'(sum_b),      32'd15);
        check("ovf_next_overflow", 32'(overflow_b), 32'd0);
        drive_b(0, 0, 0, 1);

        // Random traffic on both instances.
        for (int i = 0; i < 600; i++) begin
            in_valid    = ($urandom_range(0, 9) < 7);
            product     = PROD_W'($urandom_range(0, 189));
            clear       = ($urandom_range(0, 29) == 0);
            out_ready   = ($urandom_range(0, 1) == 1);
            in_valid_b  = ($urandom_range(0, 9) < 7);
            product_b   = PROD_W'($urandom_range(0, 189));
            clear_b     = ($urandom_range(0, 29) == 0);
            out_ready_b = ($urandom_range(0, 1) == 1);
            cyc();
        end

        in_valid    = 1'b0;
        clear       = 1'b0;
        out_ready   = 1'b1;
        in_valid_b  = 1'b0;
        clear_b     = 1'b0;
        out_ready_b = 1'b1;
        repeat (3) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
